// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch stage with Enable/MOC memory handshake and MIPS delay-slot redirects.
//   Clk, reset            : clock, synchronous active-high reset
//   mem_enable, mem_addr  : word read request to instruction memory (held during REQ)
//   mem_data, mem_moc     : returned big-endian word and its completion strobe
//   inst_valid, inst_ready: ir handshake towards the control unit
//   ir and fields         : instruction register and its decoded bit fields
//   inst_pc, pc_plus4     : fetch address of ir and that address plus 4
//   redirect_valid/_pc    : taken branch/jump for the instruction being consumed
//   in_delay_slot         : ir is the delay-slot instruction of a taken branch
//   fetch_error, err_cause: sticky error (01 MOC timeout, 10 misaligned redirect)
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h00000000,
    parameter int          MOC_TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        reset,
    output logic        mem_enable,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_moc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        in_delay_slot,
    output logic        fetch_error,
    output logic [1:0]  err_cause
);
    typedef enum logic [1:0] {IDLE, REQ, VALID, ERROR} state_t;
    localparam int CW = $clog2(MOC_TIMEOUT + 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [31:0]   pc, target;
    logic          pending;
    logic          consume, misaligned, take, resume, timeout;

    assign consume    = state == VALID && inst_ready;
    assign misaligned = redirect_valid && redirect_pc[1:0] != 2'b00;
    // A branch sitting in a delay slot is ignored; only a fresh branch arms a redirect.
    assign take       = redirect_valid && !in_delay_slot && !misaligned;
    // Consuming the delay slot of an armed branch sends fetch to the saved target.
    assign resume     = in_delay_slot && pending;
    // Fires on the MOC_TIMEOUT-th consecutive REQ cycle without completion.
    assign timeout    = !mem_moc && cnt == CW'(MOC_TIMEOUT - 1);

    assign mem_enable  = state == REQ;
    assign mem_addr    = pc;
    assign inst_valid  = state == VALID;
    assign fetch_error = state == ERROR;
    assign opcode      = ir[31:26];
    assign rs          = ir[25:21];
    assign rt          = ir[20:16];
    assign rd          = ir[15:11];
    assign shamt       = ir[10:6];
    assign funct       = ir[5:0];
    assign imm16       = ir[15:0];

    always_ff @(posedge Clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = REQ;
            REQ:     state_next = mem_moc ? VALID : (timeout ? ERROR : REQ);
            VALID:   state_next = inst_ready ? (misaligned ? ERROR : REQ) : VALID;
            default: state_next = ERROR;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            ir            <= '0;
            inst_pc       <= '0;
            pc_plus4      <= 32'd4;
            in_delay_slot <= 1'b0;
            pending       <= 1'b0;
            target        <= '0;
            err_cause     <= 2'b00;
            cnt           <= '0;
        end else begin
            if (state == REQ) begin
                if (mem_moc) begin
                    ir            <= mem_data;
                    inst_pc       <= pc;
                    pc_plus4      <= pc + 32'd4;
                    // pending is set exactly while the delay slot is being fetched.
                    in_delay_slot <= pending;
                    cnt           <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                    if (timeout)
                        err_cause <= 2'b01;
                end
            end
            if (consume) begin
                if (misaligned) begin
                    err_cause <= 2'b10;
                end else begin
                    pc <= resume ? target : pc_plus4;
                    if (take) begin
                        pending <= 1'b1;
                        target  <= redirect_pc;
                    end else if (resume) begin
                        pending <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch stage between the program counter and the control unit.
- Owns the fetch PC and issues byte-addressed word reads to instruction memory using the Enable / MOC handshake.
- Latches the returned big-endian word into an instruction register and splits it into fields for the control unit and register file.
- Applies MIPS branch/jump redirects with one architectural delay slot, and flags memory timeouts and misaligned targets.

Parameters:
RESET_PC, 32'h00000000, fetch address after reset
MOC_TIMEOUT, 16, max cycles in REQ without mem_moc before error (min 1)

Ports:
Clk  in  1  clock
reset  in  1  synchronous active-high reset
mem_enable  out  1  instruction memory read request
mem_addr  out  32  byte address of word being fetched
mem_data  in  32  instruction word {Mem[a],Mem[a+1],Mem[a+2],Mem[a+3]}
mem_moc  in  1  memory operation complete; mem_data valid
inst_valid  out  1  ir holds an unconsumed instruction
inst_ready  in  1  downstream consumes ir this cycle
ir  out  32  instruction register
opcode  out  6  ir[31:26]
rs  out  5  ir[25:21]
rt  out  5  ir[20:16]
rd  out  5  ir[15:11]
shamt  out  5  ir[10:6]
funct  out  6  ir[5:0]
imm16  out  16  ir[15:0]
inst_pc  out  32  address ir was fetched from
pc_plus4  out  32  inst_pc+4, wraps modulo 2^32
redirect_valid  in  1  branch/jump taken for the instruction being consumed
redirect_pc  in  32  target address
in_delay_slot  out  1  ir is a delay-slot instruction
fetch_error  out  1  sticky error
err_cause  out  2  01 MOC timeout, 10 misaligned redirect, 00 none

Behaviour:
- States: IDLE, REQ, VALID, ERROR.
- All outputs are driven from registers or the state register.

Reset:
- On a reset edge: state=IDLE; pc=RESET_PC; ir=0; inst_pc=0; inst_valid=0; mem_enable=0; in_delay_slot=0; pending=0; fetch_error=0; err_cause=00; timeout counter=0.
- Reset asserted mid-transaction abandons it. mem_enable is 0 from the cycle after the reset edge, and any late mem_moc is ignored.

IDLE:
- Go to REQ unconditionally next cycle.

REQ:
- mem_enable=1 and mem_addr=pc, both held stable until completion.
- Counter increments each cycle mem_moc=0.
- On an edge with mem_moc=1: ir<=mem_data, inst_pc<=pc, counter<=0, go to VALID. Minimum latency from entering REQ is 1 cycle.
- If the counter reaches MOC_TIMEOUT with mem_moc still 0: go to ERROR, err_cause=01.

VALID:
- inst_valid=1; ir and all fields held stable.
- On an edge with inst_ready=1 (consume):
  - If redirect_valid=1, in_delay_slot=0 and redirect_pc[1:0]==0: pending<=1, target<=redirect_pc, next pc<=inst_pc+4 (delay slot); the next fetched ir gets in_delay_slot=1.
  - If redirect_valid=1 and redirect_pc[1:0]!=0: go to ERROR, err_cause=10.
  - If redirect_valid=1 and in_delay_slot=1 (branch in delay slot): the redirect is ignored.
  - If in_delay_slot=1 and pending=1: next pc<=target, pending<=0.
  - Otherwise: next pc<=inst_pc+4.
  - Then go to REQ. inst_valid drops the cycle after consumption, so back-to-back throughput is one instruction per 2 cycles with zero-wait memory.
- redirect_valid is ignored when inst_ready=0.

ERROR:
- mem_enable=0, inst_valid=0, fetch_error=1; err_cause holds its value.
- Only reset exits ERROR.

Width rules:
- All PC arithmetic is 32-bit unsigned, modulo 2^32; 32'hFFFFFFFC+4 = 0.

Test Plan:
- Reset, memory answers MOC on 1st REQ cycle with words 0x2401002C, 0x00002821 → mem_addr 0, then 4; ir/inst_pc match; opcode=6'b001001, rt=1, imm16=0x002C; inst_valid high 1 cycle each.
- MOC delayed 3 cycles, inst_ready held low 5 cycles → mem_addr/mem_enable stable during wait; ir stable and inst_valid high until consume; no fetch while inst_valid=1.
- BGTZ at 0x18 consumed with redirect_valid=1, redirect_pc=0x0C → next fetch 0x1C with in_delay_slot=1, then 0x0C with in_delay_slot=0.
- Redirect asserted while consuming the delay-slot instruction → ignored; fetch proceeds to the original target.
- mem_moc never asserted, MOC_TIMEOUT=16 → fetch_error=1, err_cause=01 after 16 REQ cycles; redirect_pc=0x0000000E → err_cause=10; reset clears both and mem_addr returns to RESET_PC.
- reset asserted during REQ with mem_moc arriving the same cycle → ir stays 0, inst_valid 0; fetch restarts at RESET_PC.
